// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the alu_exec execute stage.
// Provides opcode encodings, flag-byte bit positions and the state
// encoding used by the multiply sequencing (ALU_EXEC_MUL_EN builds).
package alu_pkg;

  typedef logic [0:0] state_t;
  typedef logic [3:0] flags_t;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SHL   = 4'd5;
  localparam logic [3:0] OP_SHR   = 4'd6;
  localparam logic [3:0] OP_PASSB = 4'd7;
  localparam logic [3:0] OP_MUL   = 4'd8;

  localparam int FLG_Z = 3;
  localparam int FLG_N = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_MUL  = 1'b1;

endpackage

// File: rtl/alu_exec_if.sv
// alu_exec_if: operand/result handshake bundle for the execute stage.
// Upstream side: in_valid/in_ready, op, a, b, rd.
// Downstream side: out_valid/out_ready, result, rd_out, reg_write,
// flags {Z,N,C,V}, illegal.
// master = the environment (register file / decode / write-back),
// slave  = the execute stage.
interface alu_exec_if #(
  parameter int W  = 8,
  parameter int RW = 3
);
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    op;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [RW-1:0] rd;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic [RW-1:0] rd_out;
  logic          reg_write;
  logic [3:0]    flags;
  logic          illegal;

  modport master (
    output in_valid, op, a, b, rd, out_ready,
    input  in_ready, out_valid, result, rd_out, reg_write, flags, illegal
  );

  modport slave (
    input  in_valid, op, a, b, rd, out_ready,
    output in_ready, out_valid, result, rd_out, reg_write, flags, illegal
  );
endinterface

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: W-iteration shift-add unsigned multiplier.
// Ports: clk, rst (async, active-high), start (load operands a/b),
// done (high during the final iteration cycle), product (2W bits, valid
// while done is high; it already includes the final partial product).
module alu_mul_seq #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           done,
  output logic [2*W-1:0] product
);
  localparam int CW = $clog2(W);

  logic           busy_q, busy_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   mcand_q, mcand_d;
  logic [W-1:0]   mplier_q, mplier_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [2*W-1:0] addend;

  always_comb begin
    addend   = mplier_q[0] ? ({{W{1'b0}}, mcand_q} << cnt_q) : '0;
    product  = acc_q + addend;
    done     = busy_q && (cnt_q == CW'(W - 1));
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    if (start) begin
      busy_d   = 1'b1;
      cnt_d    = '0;
      mcand_d  = a;
      mplier_d = b;
      acc_d    = '0;
    end else if (busy_q) begin
      acc_d    = product;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (done) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
    acc_q    <= acc_d;
  end
endmodule

// File: rtl/alu_exec.sv
// alu_exec: execute stage between the 8x8 register file and its write port.
// Ports: clk, rst (async, active-high), bus (alu_exec_if.slave) carrying
// the operand handshake (in_valid/in_ready, op, a, b, rd) and the result
// handshake (out_valid/out_ready, result, rd_out, reg_write, flags,
// illegal). One output holding register; single-cycle ops complete one
// edge after accept.
// Build option ALU_EXEC_MUL_EN: when defined, opcode 8 is a W-cycle
// shift-add multiply; when undefined, opcode 8 is treated as illegal.
module alu_exec
  import alu_pkg::*;
#(
  parameter int W  = 8,
  parameter int RW = 3
) (
  input logic       clk,
  input logic       rst,
  alu_exec_if.slave bus
);
  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  result_q, result_d;
  logic [RW-1:0] rd_out_q, rd_out_d;
  logic          reg_write_q, reg_write_d;
  flags_t        flags_q, flags_d;
  logic          illegal_q, illegal_d;
  logic          in_ready;
  logic          accept;

  logic [W:0]    sum, diff;
  logic [W-1:0]  alu_res;
  logic          alu_c, alu_v, alu_legal;

  function automatic flags_t mk_flags(input logic [W-1:0] r, input logic c, input logic v);
    flags_t f;
    f        = '0;
    f[FLG_Z] = (r == '0);
    f[FLG_N] = r[W-1];
    f[FLG_C] = c;
    f[FLG_V] = v;
    return f;
  endfunction

`ifdef ALU_EXEC_MUL_EN
  state_t         state_q, state_d;
  logic [RW-1:0]  mul_rd_q, mul_rd_d;
  logic           mul_start, mul_done;
  logic [2*W-1:0] mul_prod;

  assign in_ready  = (state_q == ST_IDLE) && (!out_valid_q || bus.out_ready);
  assign mul_start = accept && (bus.op == OP_MUL);

  alu_mul_seq #(.W(W)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (bus.a),
    .b       (bus.b),
    .done    (mul_done),
    .product (mul_prod)
  );
`else
  assign in_ready = !out_valid_q || bus.out_ready;
`endif

  assign accept = bus.in_valid && in_ready;

  // Single-cycle datapath; carry/borrow taken from the (W+1)-bit sum/diff.
  always_comb begin
    sum       = {1'b0, bus.a} + {1'b0, bus.b};
    diff      = {1'b0, bus.a} - {1'b0, bus.b};
    alu_res   = '0;
    alu_c     = 1'b0;
    alu_v     = 1'b0;
    alu_legal = 1'b1;
    case (bus.op)
      OP_ADD: begin
        alu_res = sum[W-1:0];
        alu_c   = sum[W];
        alu_v   = (bus.a[W-1] == bus.b[W-1]) && (sum[W-1] != bus.a[W-1]);
      end
      OP_SUB: begin
        alu_res = diff[W-1:0];
        alu_c   = diff[W];
        alu_v   = (bus.a[W-1] != bus.b[W-1]) && (diff[W-1] != bus.a[W-1]);
      end
      OP_AND:   alu_res = bus.a & bus.b;
      OP_OR:    alu_res = bus.a | bus.b;
      OP_XOR:   alu_res = bus.a ^ bus.b;
      OP_SHL: begin
        alu_res = {bus.a[W-2:0], 1'b0};
        alu_c   = bus.a[W-1];
      end
      OP_SHR: begin
        alu_res = {1'b0, bus.a[W-1:1]};
        alu_c   = bus.a[0];
      end
      OP_PASSB: alu_res = bus.b;
      default:  alu_legal = 1'b0;
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q && !bus.out_ready;
    result_d    = result_q;
    rd_out_d    = rd_out_q;
    reg_write_d = reg_write_q;
    flags_d     = flags_q;
    illegal_d   = illegal_q;
`ifdef ALU_EXEC_MUL_EN
    state_d     = state_q;
    mul_rd_d    = mul_rd_q;
    // A multiply only parks the destination; outputs load when it finishes.
    if (mul_start) begin
      state_d  = ST_MUL;
      mul_rd_d = bus.rd;
    end else
`endif
    if (accept) begin
      out_valid_d = 1'b1;
      rd_out_d    = bus.rd;
      if (alu_legal) begin
        result_d    = alu_res;
        reg_write_d = 1'b1;
        illegal_d   = 1'b0;
        flags_d     = mk_flags(alu_res, alu_c, alu_v);
      end else begin
        // Undefined opcode: no write-back, flags keep the last legal op.
        result_d    = '0;
        reg_write_d = 1'b0;
        illegal_d   = 1'b1;
      end
    end
`ifdef ALU_EXEC_MUL_EN
    if ((state_q == ST_MUL) && mul_done) begin
      state_d     = ST_IDLE;
      out_valid_d = 1'b1;
      result_d    = mul_prod[W-1:0];
      rd_out_d    = mul_rd_q;
      reg_write_d = 1'b1;
      illegal_d   = 1'b0;
      flags_d     = mk_flags(mul_prod[W-1:0], |mul_prod[2*W-1:W], 1'b0);
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      rd_out_q    <= '0;
      reg_write_q <= 1'b0;
      flags_q     <= '0;
      illegal_q   <= 1'b0;
`ifdef ALU_EXEC_MUL_EN
      state_q     <= ST_IDLE;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      rd_out_q    <= rd_out_d;
      reg_write_q <= reg_write_d;
      flags_q     <= flags_d;
      illegal_q   <= illegal_d;
`ifdef ALU_EXEC_MUL_EN
      state_q     <= state_d;
`endif
    end
  end

`ifdef ALU_EXEC_MUL_EN
  always_ff @(posedge clk) begin
    mul_rd_q <= mul_rd_d;
  end
`endif

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.rd_out    = rd_out_q;
  assign bus.reg_write = reg_write_q;
  assign bus.flags     = flags_q;
  assign bus.illegal   = illegal_q;
endmodule

// File: doc/alu_exec.md
Name: alu_exec

Overview:
- Execute stage directly downstream of the 8-register, 8-bit register file: consumes its A/B operand outputs plus the decoded opcode and destination index.
- Produces an 8-bit result, write-enable and destination for the register-file write port (its 8-bit write-data input), plus a registered flags byte.
- Single-cycle logic/arith ops; multi-cycle shift-add multiply.
- Valid/ready handshake on both sides; one output holding register.

Parameters:
- W, 8, datapath width (register-file word width).
- RW, 3, destination-index width (8 registers).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset: asynchronous, active-high.
- in_valid  input  1  operands/opcode valid.
- in_ready  output  1  stage can accept this cycle.
- op  input  4  opcode.
- a  input  W  operand A from register file.
- b  input  W  operand B from register file.
- rd  input  RW  destination register index.
- out_valid  output  1  result valid.
- out_ready  input  1  write-back accepts result.
- result  output  W  result to register-file write data.
- rd_out  output  RW  destination index for the write.
- reg_write  output  1  write enable; qualified by out_valid.
- flags  output  4  {Z,N,C,V} of the last completed op.
- illegal  output  1  last completed op had an undefined opcode.

Behaviour:
- Reset (async, any state, including mid-multiply): state=IDLE; out_valid=0, result=0, rd_out=0, reg_write=0, flags=0, illegal=0. An in-flight multiply is discarded; no output is produced for it.
- Accept: in_valid && in_ready at a rising edge.
- in_ready = (state==IDLE) && (!out_valid || out_ready).
- Throughput: one op per cycle for non-MUL ops under continuous out_ready.
- Output transfer: out_valid && out_ready. If out_ready=0, result, rd_out, reg_write, flags and illegal hold stable, and no new op is accepted.
- Opcodes:
  - 0 ADD: a+b. C=carry-out; V=signed overflow.
  - 1 SUB: a-b. C=borrow (a<b unsigned); V=signed overflow.
  - 2 AND, 3 OR, 4 XOR: C=0, V=0.
  - 5 SHL: a<<1. C=a[7], V=0.
  - 6 SHR: logical a>>1. C=a[0], V=0.
  - 7 PASSB: result=b. C=0, V=0.
  - 8 MUL: unsigned a*b. result=product[7:0]; C=|product[15:8]; V=0.
  - 9-15 illegal: result=0, reg_write=0, illegal=1, flags unchanged.
- Z=(result==0) and N=result[W-1] for all legal ops. Legal ops set reg_write=1 and illegal=0.
- Latency, non-MUL: accepted at edge N; out_valid=1 after edge N; all outputs registered.
- MUL state machine:
  - IDLE -> MUL on accept; latch a into the multiplicand, b into the multiplier, clear the 16-bit accumulator, counter=0.
  - Each MUL cycle: if multiplier[0], add (multiplicand<<counter) to the accumulator; shift the multiplier right; counter+1.
  - At counter==W-1 (the 8th iteration edge, N+8): load the outputs, out_valid=1, return to IDLE.
  - in_ready=0 throughout MUL.
- All arithmetic is W-bit wrap-around; the carry/borrow is computed at W+1 bits.
- A transfer and a new accept in the same edge are both legal; the new result replaces the old one.

Optional Feature:
- Macro: ALU_EXEC_MUL_EN.
- Defined: MUL implemented as above, with the MUL state and a 16-bit accumulator.
- Undefined: no MUL state or datapath; opcode 8 treated as illegal (result=0, reg_write=0, illegal=1, latency 1).

Decomposition:
- Shared package alu_pkg:
  - Opcode localparams: OP_ADD..OP_MUL.
  - Flag bit indices: FLG_Z=3, FLG_N=2, FLG_C=1, FLG_V=0.
  - State encoding: ST_IDLE, ST_MUL.
- One sub-module: alu_mul_seq, the shift-add multiplier (start/done, 16-bit product), instantiated only under ALU_EXEC_MUL_EN.
- Combinational single-cycle ops stay inline.

Test Plan:
- rst pulsed mid-MUL (edge N+4) -> all outputs 0 immediately (async); state IDLE; in_ready=1 after release; no stale out_valid.
- ADD a=0x7F, b=0x01, out_ready=1 -> next cycle result=0x80, flags Z0 N1 C0 V1, reg_write=1, rd_out echoed.
- SUB a=0x05, b=0x05 then SUB a=0x00, b=0x01 back-to-back -> first result 0x00 with Z=1, C=0; second result 0xFF with N=1, C=1; one result per cycle.
- MUL a=0x10, b=0x11 -> in_ready=0 for 8 cycles; then result=0x10, C=1 (product 0x0110); with the macro undefined, illegal=1 and reg_write=0 instead.
- out_ready held 0 for 3 cycles after an AND 0xF0&0x3C -> result 0x30 held stable, in_ready=0, the next op is accepted on the edge where out_ready=1.
- op=0xC -> illegal=1, reg_write=0, result=0, flags unchanged from the previous op.
